// File: rtl/ysyx_24100005_register_file.sv
// Architectural state of the ysyx_24100005 RV32 core: GPR file, PC register, write-back and next-PC key muxes.
// Define YSYX_24100005_RV32E_EN to implement only x0-x15; upper addresses read 0 and ignore writes.
module ysyx_24100005_register_file #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1addr,
    input  logic [ADDR_WIDTH-1:0] rs2addr,
    output logic [DATA_WIDTH-1:0] rs1data,
    output logic [DATA_WIDTH-1:0] rs2data,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [1:0]            wb_sel,
    input  logic [DATA_WIDTH-1:0] alu_res,
    input  logic [DATA_WIDTH-1:0] mem_res,
    input  logic                  pc_sel,
    input  logic [DATA_WIDTH-1:0] target,
    input  logic                  pc_wen,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] snpc,
    output logic [DATA_WIDTH-1:0] wdata
);

`ifdef YSYX_24100005_RV32E_EN
    localparam int IDX_WIDTH = 4;
`else
    localparam int IDX_WIDTH = ADDR_WIDTH;
`endif
    localparam int ENTRIES = 1 << IDX_WIDTH;

    logic [DATA_WIDTH-1:0] regs [ENTRIES];
    logic [DATA_WIDTH-1:0] next_pc;
    logic [IDX_WIDTH-1:0]  widx;
    logic [IDX_WIDTH-1:0]  r1idx;
    logic [IDX_WIDTH-1:0]  r2idx;
    logic                  wvalid;
    logic                  r1valid;
    logic                  r2valid;

    assign widx  = waddr[IDX_WIDTH-1:0];
    assign r1idx = rs1addr[IDX_WIDTH-1:0];
    assign r2idx = rs2addr[IDX_WIDTH-1:0];

    // An address is only valid when its upper bits are clear, so x16-x31 never alias onto x0-x15.
`ifdef YSYX_24100005_RV32E_EN
    assign wvalid  = (waddr[ADDR_WIDTH-1:IDX_WIDTH] == '0);
    assign r1valid = (rs1addr[ADDR_WIDTH-1:IDX_WIDTH] == '0);
    assign r2valid = (rs2addr[ADDR_WIDTH-1:IDX_WIDTH] == '0);
`else
    assign wvalid  = 1'b1;
    assign r1valid = 1'b1;
    assign r2valid = 1'b1;
`endif

    assign snpc = pc + DATA_WIDTH'(4);

    always_comb begin
        wdata = alu_res;
        case (wb_sel)
            2'd0:    wdata = alu_res;
            2'd1:    wdata = snpc;
            2'd2:    wdata = mem_res;
            default: wdata = alu_res;
        endcase
    end

    always_comb begin
        next_pc = snpc;
        case (pc_sel)
            1'b0:    next_pc = snpc;
            1'b1:    next_pc = target;
            default: next_pc = snpc;
        endcase
    end

    // x0 is forced to zero on read, so the array entry behind it is never written.
    assign rs1data = (r1valid && (r1idx != '0)) ? regs[r1idx] : '0;
    assign rs2data = (r2valid && (r2idx != '0)) ? regs[r2idx] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= PC_RESET;
        end else if (pc_wen) begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                regs[i] <= '0;
            end
        end else if (wen && wvalid && (widx != '0)) begin
            regs[widx] <= wdata;
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_register_file.sv
// Self-checking bench for ysyx_24100005_register_file: directed vectors plus a per-cycle reference model.
// Honours YSYX_24100005_RV32E_EN when computing expectations for addresses 16-31.
module tb_ysyx_24100005_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1addr;
    logic [4:0]  rs2addr;
    logic [31:0] rs1data;
    logic [31:0] rs2data;
    logic        wen;
    logic [4:0]  waddr;
    logic [1:0]  wb_sel;
    logic [31:0] alu_res;
    logic [31:0] mem_res;
    logic        pc_sel;
    logic [31:0] target;
    logic        pc_wen;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;
    bit compare_en = 1'b0;

    logic [31:0] model_regs [32];
    logic [31:0] model_pc;

`ifdef YSYX_24100005_RV32E_EN
    localparam int MODEL_ENTRIES = 16;
    localparam logic [31:0] X20_EXPECT = 32'h0;
`else
    localparam int MODEL_ENTRIES = 32;
    localparam logic [31:0] X20_EXPECT = 32'hAA;
`endif

    ysyx_24100005_register_file dut (
        .clk     (clk),
        .rst     (rst),
        .rs1addr (rs1addr),
        .rs2addr (rs2addr),
        .rs1data (rs1data),
        .rs2data (rs2data),
        .wen     (wen),
        .waddr   (waddr),
        .wb_sel  (wb_sel),
        .alu_res (alu_res),
        .mem_res (mem_res),
        .pc_sel  (pc_sel),
        .target  (target),
        .pc_wen  (pc_wen),
        .pc      (pc),
        .snpc    (snpc),
        .wdata   (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_wdata();
        if (wb_sel == 2'd1) return model_pc + 32'd4;
        if (wb_sel == 2'd2) return mem_res;
        return alu_res;
    endfunction

    // Reference state: registers hold whatever was last legally written, PC follows the selected source.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_pc <= 32'h8000_0000;
            for (int i = 0; i < 32; i++) model_regs[i] <= 32'h0;
        end else begin
            if (wen && waddr != 5'd0 && int'(waddr) < MODEL_ENTRIES)
                model_regs[waddr] <= model_wdata();
            if (pc_wen)
                model_pc <= pc_sel ? target : model_pc + 32'd4;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compare_en) begin
            checkOutput("cmp_pc", pc, model_pc);
            checkOutput("cmp_snpc", snpc, model_pc + 32'd4);
            checkOutput("cmp_wdata", wdata, model_wdata());
            checkOutput("cmp_rs1data", rs1data, model_regs[rs1addr]);
            checkOutput("cmp_rs2data", rs2data, model_regs[rs2addr]);
        end
    end

    task automatic applyStimulus(input logic w_en, input logic [4:0] w_addr, input logic [1:0] w_sel,
                                 input logic [31:0] alu, input logic [31:0] mem,
                                 input logic p_wen, input logic p_sel, input logic [31:0] tgt);
        wen     = w_en;
        waddr   = w_addr;
        wb_sel  = w_sel;
        alu_res = alu;
        mem_res = mem;
        pc_wen  = p_wen;
        pc_sel  = p_sel;
        target  = tgt;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        rs1addr = 5'd0;
        rs2addr = 5'd0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        checkOutput("reset_pc", pc, 32'h8000_0000);
        checkOutput("reset_snpc", snpc, 32'h8000_0004);
        for (int i = 0; i < 32; i++) begin
            rs1addr = 5'(i);
            rs2addr = 5'(31 - i);
            #1;
            checkOutput("reset_rs1", rs1data, 32'h0);
            checkOutput("reset_rs2", rs2data, 32'h0);
        end

        @(negedge clk);
        #2;
        rst = 1'b1;
        compare_en = 1'b1;
        tick();

        rs1addr = 5'd5;
        rs2addr = 5'd5;
        applyStimulus(1, 5, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);
        checkOutput("raw_old_value", rs1data, 32'h0);
        tick();
        checkOutput("x5_rs1", rs1data, 32'hDEAD_BEEF);
        checkOutput("x5_rs2", rs2data, 32'hDEAD_BEEF);

        applyStimulus(1, 0, 0, 32'h1234, 0, 0, 0, 0);
        rs1addr = 5'd0;
        tick();
        checkOutput("x0_zero", rs1data, 32'h0);

        applyStimulus(1, 1, 3, 32'h55, 32'h77, 0, 0, 0);
        checkOutput("wb_default", wdata, 32'h55);
        tick();
        rs1addr = 5'd1;
        #1;
        checkOutput("x1_default", rs1data, 32'h55);

        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) tick();
        checkOutput("pc_seq3", pc, 32'h8000_000C);
        tick();
        checkOutput("pc_seq4", pc, 32'h8000_0010);
        applyStimulus(1, 2, 1, 0, 0, 0, 0, 0);
        checkOutput("wb_snpc", wdata, 32'h8000_0014);
        tick();
        rs1addr = 5'd2;
        #1;
        checkOutput("x2_snpc", rs1data, 32'h8000_0014);

        applyStimulus(1, 3, 2, 0, 32'hFFFF_FF80, 0, 0, 0);
        tick();
        rs1addr = 5'd3;
        #1;
        checkOutput("x3_mem", rs1data, 32'hFFFF_FF80);

        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h8000_0100);
        tick();
        checkOutput("pc_target", pc, 32'h8000_0100);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0);
        repeat (2) tick();
        checkOutput("pc_hold", pc, 32'h8000_0100);

        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFFC);
        tick();
        checkOutput("pc_top", pc, 32'hFFFF_FFFC);
        checkOutput("snpc_wrap", snpc, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        checkOutput("pc_wrapped", pc, 32'h0);

        applyStimulus(1, 6, 1, 0, 0, 1, 1, 32'h8000_0200);
        checkOutput("wb_snpc_zero", wdata, 32'h4);
        tick();
        rs2addr = 5'd6;
        #1;
        checkOutput("dual_pc", pc, 32'h8000_0200);
        checkOutput("dual_x6", rs2data, 32'h4);

        applyStimulus(1, 4, 0, 32'h44, 0, 0, 0, 0);
        tick();
        applyStimulus(1, 20, 0, 32'hAA, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        rs1addr = 5'd20;
        rs2addr = 5'd4;
        #1;
        checkOutput("x20_upper", rs1data, X20_EXPECT);
        checkOutput("x4_kept", rs2data, 32'h44);

        @(posedge clk);
        #3;
        rst = 1'b0;
        rs1addr = 5'd5;
        #1;
        checkOutput("async_pc", pc, 32'h8000_0000);
        checkOutput("async_snpc", snpc, 32'h8000_0004);
        checkOutput("async_x5", rs1data, 32'h0);
        applyStimulus(1, 7, 0, 32'h99, 0, 1, 1, 32'h8000_0300);
        rs1addr = 5'd7;
        tick();
        checkOutput("blocked_pc", pc, 32'h8000_0000);
        checkOutput("blocked_x7", rs1data, 32'h0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("release_pc", pc, 32'h8000_0000);
        checkOutput("release_x7", rs1data, 32'h0);
        tick();
        checkOutput("resume_pc", pc, 32'h8000_0300);
        checkOutput("resume_x7", rs1data, 32'h99);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        compare_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_register_file.md
# ysyx_24100005_register_file

Architectural state unit of the ysyx_24100005 single-cycle RV32 core. It holds the general-purpose register file, with two combinational read ports and one synchronous write port, and the program-counter register. It also contains the key-select multiplexers that choose the register write-back source and the next PC. It sits between the decoder/ALU and the memory interface in `ysyx_24100005_top`-level datapaths.

## Interface
Parameters:
- ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH entries).
- DATA_WIDTH, 32, register and PC width.
- PC_RESET, 32'h8000_0000, PC value loaded by reset.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- rs1addr  input  ADDR_WIDTH  read port 1 address.
- rs2addr  input  ADDR_WIDTH  read port 2 address.
- rs1data  output  DATA_WIDTH  read port 1 data, combinational.
- rs2data  output  DATA_WIDTH  read port 2 data, combinational.
- wen  input  1  register write enable.
- waddr  input  ADDR_WIDTH  write address.
- wb_sel  input  2  write-back source key: 0 alu_res, 1 snpc, 2 mem_res, 3 reserved (falls to default).
- alu_res  input  DATA_WIDTH  ALU/adder result.
- mem_res  input  DATA_WIDTH  load data, already extended.
- pc_sel  input  1  next-PC key: 0 snpc, 1 target.
- target  input  DATA_WIDTH  branch/jump target.
- pc_wen  input  1  PC update enable.
- pc  output  DATA_WIDTH  current PC.
- snpc  output  DATA_WIDTH  pc + 4, combinational.
- wdata  output  DATA_WIDTH  selected write-back value, combinational.

## Operation
- Key mux: output = the data of the entry whose key equals the select. If no entry matches, output = the default.
  - wb mux: keys 0/1/2 -> alu_res/snpc/mem_res; default alu_res.
  - pc mux: keys 0/1 -> snpc/target; default snpc.
- Register file: 2^ADDR_WIDTH entries of DATA_WIDTH.
  - Entry 0 always reads 0.
  - Writes to address 0 are discarded.
  - Reads are purely combinational from rs1addr/rs2addr.
  - Both ports may read the same address.
- Write: on posedge clk with wen=1 and rst=1, entry[waddr] <= wdata (the internal wb mux output).
- PC: on posedge clk with pc_wen=1 and rst=1, pc <= pc mux output. pc holds when pc_wen=0.
- snpc = pc + 4, modulo 2^DATA_WIDTH; 0xFFFF_FFFC wraps to 0.
- Arithmetic is unsigned, with no carry-out.

## Timing
- rst low, asynchronous and immediate regardless of clk:
  - pc = PC_RESET.
  - All register entries = 0.
  - Writes are blocked while rst is low.
- On the first rising edge after rst rises, normal operation resumes. Reset released mid-cycle does not produce a partial update.
- Read-during-write to the same address in one cycle: the read returns the old value. The new value is visible after the edge; there is no bypass.
- Write latency: 1 cycle. Read latency: 0 (combinational).
- PC latency: a new value appears 1 edge after selection.
- wen and pc_wen are independent. Simultaneous register write and PC update occur on the same edge.
- snpc and wdata follow pc and the inputs combinationally within the cycle.

## Configuration
- Macro YSYX_24100005_RV32E_EN.
  - Defined: only entries 0-15 exist. Addresses 16-31 read as 0, and writes to them are discarded; the address MSB is not aliased.
  - Undefined: all 2^ADDR_WIDTH entries are implemented.

## Test plan
- Reset: hold rst=0 mid-cycle -> pc=0x8000_0000 immediately, snpc=0x8000_0004, rs1data=rs2data=0 for all addresses.
- Write/read: wen=1, waddr=5, wb_sel=0, alu_res=0xDEAD_BEEF, one edge -> rs1addr=5 and rs2addr=5 both read 0xDEAD_BEEF. Same-cycle read before the edge returns 0.
- x0 and default key: waddr=0, alu_res=0x1234 -> entry 0 stays 0. Then wb_sel=3, alu_res=0x55, mem_res=0x77 to waddr=1 -> x1=0x55.
- Write-back sources: wb_sel=1 at pc=0x8000_0010 -> rd gets 0x8000_0014. wb_sel=2, mem_res=0xFFFF_FF80 -> rd gets 0xFFFF_FF80.
- PC control:
  - pc_sel=0 for three edges -> pc=0x8000_000C.
  - pc_sel=1, target=0x8000_0100 -> pc=0x8000_0100.
  - pc_wen=0 -> pc holds.
  - target=0xFFFF_FFFC -> snpc=0x0000_0000.
- With YSYX_24100005_RV32E_EN: write 0xAA to address 20 -> reads 0. Address 4 is unaffected.
